// File: rtl/icache_def.sv
// -----------------------------------------------------------------------------
// icache_def
// Shared definitions for the instruction-cache fill unit: geometry constants,
// derived field widths, FSM state encoding, the fetch-address field split and
// a helper that breaks a halfword address into tag/index/offset.
// -----------------------------------------------------------------------------
package icache_def;

  localparam int NUM_LINES  = 16;
  localparam int LINE_WORDS = 4;

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = $clog2(LINE_WORDS);
  // Bit 0 of the byte address never selects anything (halfword granularity).
  localparam int TAG_W = 16 - IDX_W - OFF_W - 1;

  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_FILL = 2'd1,
    IC_DONE = 2'd2
  } icache_state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
  } icache_addr_t;

  // Split a halfword address (byte address without bit 0) into its fields.
  function automatic icache_addr_t split_addr(input logic [14:0] hw_addr);
    icache_addr_t fields;
    fields.offset = hw_addr[OFF_W-1:0];
    fields.index  = hw_addr[OFF_W+IDX_W-1:OFF_W];
    fields.tag    = hw_addr[14:OFF_W+IDX_W];
    return fields;
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// -----------------------------------------------------------------------------
// icache_data_array
// Instruction storage: NUM_LINES lines of LINE_WORDS 16-bit halfwords.
// Ports:
//   clk              clock for the write port
//   we               write enable
//   windex, woffset  line / halfword selected for writing
//   wdata            halfword written
//   rindex, roffset  line / halfword selected for the asynchronous read
//   rdata            halfword read (combinational)
// -----------------------------------------------------------------------------
module icache_data_array
  import icache_def::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] windex,
  input  logic [OFF_W-1:0] woffset,
  input  logic [15:0]      wdata,
  input  logic [IDX_W-1:0] rindex,
  input  logic [OFF_W-1:0] roffset,
  output logic [15:0]      rdata
);

  logic [15:0] mem [NUM_LINES*LINE_WORDS];

  // Synchronous write of one returned halfword.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{windex, woffset}] <= wdata;
    end
  end

  assign rdata = mem[{rindex, roffset}];

endmodule

// File: rtl/icache_fill_unit.sv
// -----------------------------------------------------------------------------
// icache_fill_unit
// Direct-mapped read-only instruction cache. Hits return in the same cycle;
// a miss stalls fetch while the whole line is burst-read from instruction
// memory in order (word 0 first), followed by one bubble cycle before the
// lookup is retried.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   fetch_addr    byte address of the instruction (bit 0 ignored)
//   fetch_req     fetch stage requests an instruction this cycle
//   instr         instruction on a hit, 16'h0000 otherwise
//   instr_valid   hit this cycle
//   icache_stall  fetch must hold its PC
//   mem_req       read request to instruction memory, held until mem_rvalid
//   mem_addr      byte address of the requested halfword
//   mem_rdata     returned halfword
//   mem_rvalid    mem_rdata valid; one beat consumed per cycle it is high
// -----------------------------------------------------------------------------
module icache_fill_unit
  import icache_def::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fetch_addr,
  input  logic        fetch_req,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic        icache_stall,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  icache_addr_t         fa;
  icache_state_t        state;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_arr [NUM_LINES];
  logic [TAG_W-1:0]     miss_tag;
  logic [IDX_W-1:0]     miss_index;
  logic [OFF_W-1:0]     counter;
  logic                 hit;
  logic                 fill_we;
  logic                 last_beat;
  logic [15:0]          rd_data;
  logic                 unused_bit0;

  assign fa          = split_addr(fetch_addr[15:1]);
  assign unused_bit0 = fetch_addr[0];

  assign fill_we   = (state == IC_FILL) && mem_rvalid;
  assign last_beat = fill_we && (counter == LAST_WORD);

  icache_data_array u_data (
    .clk     (clk),
    .we      (fill_we),
    .windex  (miss_index),
    .woffset (counter),
    .wdata   (mem_rdata),
    .rindex  (fa.index),
    .roffset (fa.offset),
    .rdata   (rd_data)
  );

  // Zero-cycle hit detection; lookups only happen while the FSM is idle.
  always_comb begin
    hit = 1'b0;
    if (fetch_req && (state == IC_IDLE) && valid[fa.index] &&
        (tag_arr[fa.index] == fa.tag)) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

  // Fetch-side outputs derived from the hit result and FSM state.
  always_comb begin
    instr_valid  = hit;
    icache_stall = (fetch_req && !hit) || (state != IC_IDLE);
    if (hit) begin
      instr = rd_data;
    end else begin
      instr = 16'h0000;
    end
  end

  // Tag store: written once the final beat of a line has arrived.
  always_ff @(posedge clk) begin
    if (last_beat) begin
      tag_arr[miss_index] <= miss_tag;
    end
  end

  // Line-fill FSM with registered memory request and address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IC_IDLE;
      valid      <= {NUM_LINES{1'b0}};
      counter    <= {OFF_W{1'b0}};
      miss_tag   <= {TAG_W{1'b0}};
      miss_index <= {IDX_W{1'b0}};
      mem_req    <= 1'b0;
      mem_addr   <= 16'h0000;
    end else begin
      case (state)
        IC_IDLE: begin
          if (fetch_req && !hit) begin
            // Line is invalid while it is being overwritten.
            miss_tag          <= fa.tag;
            miss_index        <= fa.index;
            valid[fa.index]   <= 1'b0;
            counter           <= {OFF_W{1'b0}};
            mem_req           <= 1'b1;
            mem_addr          <= {fa.tag, fa.index, {OFF_W{1'b0}}, 1'b0};
            state             <= IC_FILL;
          end
        end
        IC_FILL: begin
          // Without mem_rvalid the request and address simply hold.
          if (last_beat) begin
            valid[miss_index] <= 1'b1;
            mem_req           <= 1'b0;
            state             <= IC_DONE;
          end else if (mem_rvalid) begin
            counter  <= counter + {{(OFF_W-1){1'b0}}, 1'b1};
            mem_addr <= mem_addr + 16'd2;
          end
        end
        IC_DONE: begin
          state <= IC_IDLE;
        end
        default: begin
          state   <= IC_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill_unit.sv
// -----------------------------------------------------------------------------
// tb_icache_fill_unit
// Self-checking bench for icache_fill_unit. Instruction memory is a random
// image; the expected instruction for any address is simply the image
// halfword at that address. A small presence model (valid + tag per line,
// derived from address arithmetic) predicts hit or miss for each fetch.
// -----------------------------------------------------------------------------
module tb_icache_fill_unit;

  logic        clk;
  logic        rst;
  logic [15:0] fetch_addr;
  logic        fetch_req;
  logic [15:0] instr;
  logic        instr_valid;
  logic        icache_stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem_img [32768];
  bit          m_valid [16];
  int          m_tag   [16];
  bit          req_jitter = 1'b0;

  icache_fill_unit dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_addr   (fetch_addr),
    .fetch_req    (fetch_req),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .icache_stall (icache_stall),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idx_of(input logic [15:0] a);
    return (int'(a) / 8) % 16;
  endfunction

  function automatic int tag_of(input logic [15:0] a);
    return int'(a) / 128;
  endfunction

  function automatic bit m_hit(input logic [15:0] a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  // One fetch of address a. On a miss the whole fill and bubble are checked;
  // the call returns after the bubble so the next call is the retry cycle.
  // rate: memory answers on every rate-th cycle of waiting.
  // ev_beat >= 0: at that beat either redirect fetch_addr to ev_addr or reset.
  task automatic fetch(input logic [15:0] a, input int rate, input int ev_beat,
                       input logic [15:0] ev_addr, input bit ev_reset,
                       output int stalls);
    bit          exp_hit;
    int          beats;
    int          wait_c;
    int          pending;
    logic [15:0] base;
    stalls  = 0;
    pending = ev_beat;
    @(posedge clk); #1;
    rst        = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = a;
    mem_rvalid = 1'b0;
    exp_hit    = m_hit(a);
    @(negedge clk);
    checks++;
    if (instr_valid !== exp_hit || icache_stall !== !exp_hit || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL lookup %h: valid=%b stall=%b mem_req=%b, expected valid=%b stall=%b mem_req=0",
               a, instr_valid, icache_stall, mem_req, exp_hit, !exp_hit);
    end
    checks++;
    if (exp_hit) begin
      if (instr !== mem_img[a >> 1]) begin
        errors++;
        $display("FAIL hit_data %h: got %h expected %h", a, instr, mem_img[a >> 1]);
      end
    end else begin
      if (instr !== 16'h0000) begin
        errors++;
        $display("FAIL miss_instr %h: got %h expected 0000", a, instr);
      end
      stalls = 1;
      base   = a & 16'hFFF8;
      m_valid[idx_of(a)] = 1'b0;
      beats  = 0;
      wait_c = 0;
      while (beats < 4) begin
        @(posedge clk); #1;
        if (pending >= 0 && pending == beats) begin
          pending = -1;
          if (ev_reset) begin
            rst        = 1'b1;
            fetch_req  = 1'b0;
            mem_rvalid = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || icache_stall !== 1'b0 || instr_valid !== 1'b0 ||
                mem_addr !== 16'h0000) begin
              errors++;
              $display("FAIL reset_mid_fill: mem_req=%b stall=%b valid=%b mem_addr=%h, expected 0 0 0 0000",
                       mem_req, icache_stall, instr_valid, mem_addr);
            end
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            return;
          end
          fetch_addr = ev_addr;
        end
        if (req_jitter) fetch_req = 1'($urandom_range(0, 1));
        wait_c++;
        mem_rvalid = (wait_c >= rate);
        mem_rdata  = mem_img[mem_addr >> 1];
        @(negedge clk);
        stalls++;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== base + 16'(2 * beats) ||
            icache_stall !== 1'b1 || instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL fill beat %0d of %h: mem_req=%b mem_addr=%h stall=%b valid=%b, expected 1 %h 1 0",
                   beats, base, mem_req, mem_addr, icache_stall, instr_valid, base + 16'(2 * beats));
        end
        if (mem_rvalid) begin
          beats++;
          wait_c = 0;
        end
      end
      // Bubble cycle; a stray beat offered here must be ignored.
      @(posedge clk); #1;
      mem_rvalid = 1'b1;
      mem_rdata  = ~mem_img[base >> 1];
      @(negedge clk);
      stalls++;
      checks++;
      if (mem_req !== 1'b0 || icache_stall !== 1'b1 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL done_bubble %h: mem_req=%b stall=%b valid=%b, expected 0 1 0",
                 base, mem_req, icache_stall, instr_valid);
      end
      m_valid[idx_of(a)] = 1'b1;
      m_tag[idx_of(a)]   = tag_of(a);
      fetch_req = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = 16'h0000;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || icache_stall !== 1'b0 || mem_req !== 1'b0 ||
        mem_addr !== 16'h0000 || instr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: valid=%b stall=%b mem_req=%b mem_addr=%h instr=%h, expected all zero",
               instr_valid, icache_stall, mem_req, mem_addr, instr);
    end
  endtask

  task automatic test_cold_miss();
    int s;
    fetch(16'h0000, 1, -1, 16'h0000, 1'b0, s);
    checks++;
    if (s != 6) begin
      errors++;
      $display("FAIL cold_miss_stall_cycles: got %0d expected 6", s);
    end
    fetch(16'h0000, 1, -1, 16'h0000, 1'b0, s);
  endtask

  task automatic test_seq_hits();
    int s;
    fetch(16'h0002, 1, -1, 16'h0000, 1'b0, s);
    fetch(16'h0004, 1, -1, 16'h0000, 1'b0, s);
    fetch(16'h0006, 1, -1, 16'h0000, 1'b0, s);
    checks++;
    if (s != 0) begin
      errors++;
      $display("FAIL seq_hit_stalls: got %0d expected 0", s);
    end
  endtask

  task automatic test_conflict();
    int s;
    fetch(16'h0080, 1, -1, 16'h0000, 1'b0, s);
    fetch(16'h0086, 1, -1, 16'h0000, 1'b0, s);
    fetch(16'h0000, 1, -1, 16'h0000, 1'b0, s);
    fetch(16'h0000, 1, -1, 16'h0000, 1'b0, s);
  endtask

  task automatic test_slow_mem();
    int s;
    fetch(16'h0100, 3, -1, 16'h0000, 1'b0, s);
    checks++;
    if (s != 14) begin
      errors++;
      $display("FAIL slow_mem_stall_cycles: got %0d expected 14", s);
    end
    for (int k = 0; k < 4; k++) fetch(16'h0100 + 16'(2 * k), 1, -1, 16'h0000, 1'b0, s);
  endtask

  task automatic test_redirect();
    int s;
    fetch(16'h0000, 1, 2, 16'h0040, 1'b0, s);
    fetch(16'h0040, 1, -1, 16'h0000, 1'b0, s);
    fetch(16'h0042, 1, -1, 16'h0000, 1'b0, s);
    fetch(16'h0006, 1, -1, 16'h0000, 1'b0, s);
  endtask

  task automatic test_reset_mid_fill();
    int s;
    fetch(16'h0200, 1, 2, 16'h0000, 1'b1, s);
    fetch(16'h0000, 1, -1, 16'h0000, 1'b0, s);
    fetch(16'h0004, 1, -1, 16'h0000, 1'b0, s);
  endtask

  task automatic test_random();
    int          s;
    logic [15:0] a;
    logic [15:0] b;
    req_jitter = 1'b1;
    for (int n = 0; n < 60; n++) begin
      a = 16'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 3) |
              ($urandom_range(0, 3) << 1) | $urandom_range(0, 1));
      b = 16'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 3));
      if ($urandom_range(0, 4) == 0) begin
        // Idle cycle with a stray memory beat.
        @(posedge clk); #1;
        fetch_req  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'(~$urandom);
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || icache_stall !== 1'b0 || mem_req !== 1'b0) begin
          errors++;
          $display("FAIL idle_cycle: valid=%b stall=%b mem_req=%b, expected 0 0 0",
                   instr_valid, icache_stall, mem_req);
        end
      end
      fetch(a, $urandom_range(1, 3), ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1,
            b, 1'b0, s);
    end
    req_jitter = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem_img[i] = 16'($urandom);
    test_reset();
    test_cold_miss();
    test_seq_hits();
    test_conflict();
    test_slow_mem();
    test_redirect();
    test_reset_mid_fill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
